// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath and its controller.
// Holds ALUOp, funct, ALUSrcB, PCSource and opcode constants plus the
// datapath-local ALU function enum.
package mips_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  // ALUOp from the controller
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // R-type funct field
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALUSrcB select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  // Opcodes shared with the controller
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Decoded ALU operation
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_fn_t;

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear, r0 hardwired to zero.
// Ports: clk, rst_n, ra1/ra2 read addresses -> rd1/rd2, we/wa/wd write port.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [W-1:0]      wd,
  output logic [W-1:0]      rd1,
  output logic [W-1:0]      rd2
);

  logic [W-1:0] regs [NREGS];

  // Storage; writes to r0 are dropped so the entry stays zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Datapath half of the multicycle MIPS core: PC, IR, MDR, A, B, ALUOut,
// register file, ALU with local ALU-control decode, shared memory port.
// Ports: clk, rst_n; control strobes from the controller; opcode/zero back
// to it; mem_addr/mem_wdata/mem_rdata/mem_read/mem_write to memory
// (combinational read data).
module multicycle_datapath
  import mips_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic              RegDst,
  input  logic              ALUSrcA,
  input  logic [1:0]        PCSource,
  input  logic [1:0]        ALUOp,
  input  logic [1:0]        ALUSrcB,
  output logic [5:0]        opcode,
  output logic              zero,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write
);

  logic [DATA_W-1:0] pc, ir, mdr, a_reg, b_reg, alu_out;
  logic [DATA_W-1:0] rd1, rd2, imm_sx, src_a, src_b, alu_res, pc_next, rf_wd;
  logic [REG_AW-1:0] rf_wa;
  alu_fn_t           alu_fn;
  logic              pc_en;

  mips_regfile #(.W(DATA_W)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ir[25:21]),
    .ra2   (ir[20:16]),
    .we    (RegWrite),
    .wa    (rf_wa),
    .wd    (rf_wd),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  assign rf_wa  = RegDst ? ir[15:11] : ir[20:16];
  assign rf_wd  = MemToReg ? mdr : alu_out;
  assign imm_sx = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign src_a  = ALUSrcA ? a_reg : pc;

  // ALU B operand select
  always_comb begin
    src_b = b_reg;
    case (ALUSrcB)
      SRCB_REG:     src_b = b_reg;
      SRCB_FOUR:    src_b = DATA_W'(4);
      SRCB_IMM:     src_b = imm_sx;
      SRCB_IMM_SH2: src_b = imm_sx << 2;
      default:      src_b = b_reg;
    endcase
  end

  // ALU control; unlisted funct codes and ALUOp 11 fall back to add
  always_comb begin
    alu_fn = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: alu_fn = ALU_SUB;
      ALUOP_FUNCT: begin
        case (ir[5:0])
          FUNCT_SUB: alu_fn = ALU_SUB;
          FUNCT_AND: alu_fn = ALU_AND;
          FUNCT_OR:  alu_fn = ALU_OR;
          FUNCT_SLT: alu_fn = ALU_SLT;
          default:   alu_fn = ALU_ADD;
        endcase
      end
      default: alu_fn = ALU_ADD;
    endcase
  end

  // ALU; arithmetic wraps, no overflow detection
  always_comb begin
    alu_res = src_a + src_b;
    case (alu_fn)
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res = src_a + src_b;
    endcase
  end

  assign zero = (alu_res == '0);

  // Next PC select; jump keeps the PC's top nibble
  always_comb begin
    pc_next = pc;
    case (PCSource)
      PCSRC_ALU:    pc_next = alu_res;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = {pc[DATA_W-1:DATA_W-4], ir[25:0], 2'b00};
      PCSRC_HOLD:   pc_next = pc;
      default:      pc_next = pc;
    endcase
  end

  assign pc_en = PCWrite | (PCWriteCond & zero);

  // Architectural registers; A/B/MDR/ALUOut load every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      alu_out <= alu_res;
      mdr     <= mem_rdata;
      a_reg   <= rd1;
      b_reg   <= rd2;
      if (IRWrite) ir <= mem_rdata;
      if (pc_en)   pc <= pc_next;
    end
  end

  assign opcode    = ir[31:26];
  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b_reg;
  assign mem_read  = MemRead & rst_n;
  assign mem_write = MemWrite & rst_n;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: stimulus computes expected port
// values from an architectural model and queues them; a monitor compares.
module tb_multicycle_datapath;

  typedef struct packed {
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, srca;
    logic [1:0] pcs, aop, srcb;
  } ctrl_t;

  typedef struct {
    string       nm;
    logic [31:0] addr, wdata;
    logic        rd, wr, zero;
    logic [5:0]  op;
    int          kk;
    logic [31:0] kv;
  } exp_t;

  localparam int K_NONE = 0, K_ADDR = 1, K_WDATA = 2, K_ZERO = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemToReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [5:0]  opcode;
  logic        zero, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  exp_t q[$];

  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];

  multicycle_datapath dut (
    .clk(clk), .rst_n(rst_n),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .opcode(opcode), .zero(zero), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] aop, input logic [5:0] fn);
    int signed sx, sy;
    sx = x;
    sy = y;
    if (aop == 2'b01) return x - y;
    if (aop == 2'b10) begin
      if (fn == 6'h22) return x - y;
      if (fn == 6'h24) return x & y;
      if (fn == 6'h25) return x | y;
      if (fn == 6'h2A) return (sx < sy) ? 32'd1 : 32'd0;
    end
    return x + y;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  // One clock cycle: drive, queue expected outputs, advance the model
  task automatic cyc(input ctrl_t c, input logic [31:0] rdata, input logic rst,
                     input string nm, input int kk, input logic [31:0] kv);
    exp_t e;
    logic [31:0] sx, sa, sb, res, npc, na, nb;
    @(posedge clk);
    #1;
    PCWrite = c.pcw; PCWriteCond = c.pcwc; IorD = c.iord; MemRead = c.mr;
    MemWrite = c.mw; IRWrite = c.irw; MemToReg = c.m2r; RegWrite = c.rw;
    RegDst = c.rd; ALUSrcA = c.srca; PCSource = c.pcs; ALUOp = c.aop;
    ALUSrcB = c.srcb; mem_rdata = rdata; rst_n = rst;

    sx = {{16{m_ir[15]}}, m_ir[15:0]};
    sa = c.srca ? m_a : m_pc;
    case (c.srcb)
      2'd0: sb = m_b;
      2'd1: sb = 32'd4;
      2'd2: sb = sx;
      default: sb = sx * 32'd4;
    endcase
    res = ref_alu(sa, sb, c.aop, m_ir[5:0]);

    e.nm = nm; e.addr = c.iord ? m_aluout : m_pc; e.wdata = m_b;
    e.rd = c.mr & rst; e.wr = c.mw & rst; e.zero = (res == 0);
    e.op = m_ir[31:26]; e.kk = kk; e.kv = kv;
    q.push_back(e);

    if (!rst) begin
      model_reset();
    end else begin
      na = m_rf[m_ir[25:21]];
      nb = m_rf[m_ir[20:16]];
      case (c.pcs)
        2'd0: npc = res;
        2'd1: npc = m_aluout;
        2'd2: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: npc = m_pc;
      endcase
      if (c.rw) begin
        if (c.rd) begin
          if (m_ir[15:11] != 0) m_rf[m_ir[15:11]] = c.m2r ? m_mdr : m_aluout;
        end else begin
          if (m_ir[20:16] != 0) m_rf[m_ir[20:16]] = c.m2r ? m_mdr : m_aluout;
        end
      end
      if (c.pcw || (c.pcwc && res == 0)) m_pc = npc;
      m_a = na; m_b = nb; m_aluout = res; m_mdr = rdata;
      if (c.irw) m_ir = rdata;
    end
  endtask

  task automatic idle(input string nm, input int kk, input logic [31:0] kv);
    cyc('0, 32'h0, 1'b1, nm, kk, kv);
  endtask

  task automatic load_reg(input logic [4:0] r, input logic [31:0] v);
    ctrl_t c;
    c = '0; c.irw = 1;
    cyc(c, {6'h23, 5'd0, r, 16'd0}, 1'b1, "ld_ir", K_NONE, 0);
    idle("ld_mdr", K_NONE, 0);
    cyc('0, v, 1'b1, "ld_mdr", K_NONE, 0);
    c = '0; c.rw = 1; c.m2r = 1;
    cyc(c, 32'h0, 1'b1, "ld_wb", K_NONE, 0);
  endtask

  task automatic peek_reg(input logic [4:0] r, input logic [31:0] v, input string nm);
    ctrl_t c;
    c = '0; c.irw = 1;
    cyc(c, {6'h2B, 5'd0, r, 16'd0}, 1'b1, "pk_ir", K_NONE, 0);
    idle("pk_wait", K_NONE, 0);
    c = '0; c.mw = 1;
    cyc(c, 32'h0, 1'b1, nm, K_WDATA, v);
  endtask

  task automatic fetch(input logic [31:0] instr, input int kk, input logic [31:0] kv);
    ctrl_t c;
    c = '0; c.irw = 1; c.pcw = 1; c.mr = 1; c.srcb = 2'b01;
    cyc(c, instr, 1'b1, "fetch", kk, kv);
  endtask

  task automatic decode(input string nm, input int kk, input logic [31:0] kv);
    ctrl_t c;
    c = '0; c.srcb = 2'b11;
    cyc(c, 32'h0, 1'b1, nm, kk, kv);
  endtask

  task automatic rtype(input logic [31:0] instr, input logic [31:0] v, input string nm);
    ctrl_t c;
    fetch(instr, K_NONE, 0);
    decode("rt_dec", K_NONE, 0);
    c = '0; c.srca = 1; c.aop = 2'b10;
    cyc(c, 32'h0, 1'b1, "rt_exec", K_NONE, 0);
    c = '0; c.rd = 1; c.rw = 1;
    cyc(c, 32'h0, 1'b1, "rt_wb", K_NONE, 0);
    peek_reg(instr[15:11], v, nm);
  endtask

  task automatic beq_compare(input logic exp_zero, input string nm);
    ctrl_t c;
    c = '0; c.srca = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.iord = 1;
    cyc(c, 32'h0, 1'b1, nm, K_ZERO, {31'd0, exp_zero});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".mem_addr"}, mem_addr, e.addr);
        chk({e.nm, ".mem_wdata"}, mem_wdata, e.wdata);
        chk({e.nm, ".mem_read"}, 32'(mem_read), 32'(e.rd));
        chk({e.nm, ".mem_write"}, 32'(mem_write), 32'(e.wr));
        chk({e.nm, ".opcode"}, 32'(opcode), 32'(e.op));
        chk({e.nm, ".zero"}, 32'(zero), 32'(e.zero));
        case (e.kk)
          K_ADDR:  chk({e.nm, ".const_addr"}, mem_addr, e.kv);
          K_WDATA: chk({e.nm, ".const_wdata"}, mem_wdata, e.kv);
          K_ZERO:  chk({e.nm, ".const_zero"}, 32'(zero), e.kv);
          default: ;
        endcase
      end
    end
  end

  initial begin
    ctrl_t c;
    bit drained;
    c = '0; c.pcw = 1; c.rw = 1; c.mr = 1; c.mw = 1;
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite} = '0;
    {MemToReg, RegWrite, RegDst, ALUSrcA} = '0;
    PCSource = 0; ALUOp = 0; ALUSrcB = 0; mem_rdata = 32'h0; rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    cyc(c, 32'hFFFF_FFFF, 1'b0, "reset", K_ADDR, 32'h0);
    peek_reg(5'd9, 32'h0, "reset_rf9");

    // R-type add and slt
    load_reg(5'd9, 32'd7);
    load_reg(5'd2, 32'd5);
    fetch(32'h0122_5020, K_ADDR, 32'h0);
    decode("fetch_pc", K_ADDR, 32'h4);
    c = '0; c.srca = 1; c.aop = 2'b10;
    cyc(c, 32'h0, 1'b1, "add_exec", K_NONE, 0);
    c = '0; c.rd = 1; c.rw = 1;
    cyc(c, 32'h0, 1'b1, "add_wb", K_NONE, 0);
    peek_reg(5'd10, 32'd12, "add_rf10");
    load_reg(5'd9, 32'hFFFF_FFFF);
    load_reg(5'd2, 32'd1);
    rtype(32'h0122_502A, 32'd1, "slt_rf10");

    // beq taken then not taken
    c = '0; c.pcw = 1; c.rw = 1;
    cyc(c, 32'h0, 1'b0, "reset2", K_NONE, 0);
    load_reg(5'd1, 32'd3);
    load_reg(5'd2, 32'd3);
    fetch(32'h0000_0000, K_NONE, 0);
    fetch(32'h1022_FFFF, K_ADDR, 32'h4);
    decode("beq_dec", K_ADDR, 32'h8);
    beq_compare(1'b1, "beq_taken");
    idle("beq_taken_pc", K_ADDR, 32'h4);
    load_reg(5'd2, 32'd5);
    fetch(32'h1022_FFFF, K_ADDR, 32'h4);
    decode("beq_dec2", K_NONE, 0);
    beq_compare(1'b0, "beq_not_taken");
    idle("beq_nt_pc", K_ADDR, 32'h8);

    // lw $3,8($4) then sw-style read of $3
    load_reg(5'd4, 32'h100);
    fetch(32'h8C83_0008, K_NONE, 0);
    decode("lw_dec", K_NONE, 0);
    c = '0; c.srca = 1; c.srcb = 2'b10;
    cyc(c, 32'h0, 1'b1, "lw_addr", K_NONE, 0);
    c = '0; c.iord = 1; c.mr = 1;
    cyc(c, 32'hDEAD_BEEF, 1'b1, "lw_mem", K_ADDR, 32'h108);
    c = '0; c.rw = 1; c.m2r = 1;
    cyc(c, 32'h0, 1'b1, "lw_wb", K_NONE, 0);
    peek_reg(5'd3, 32'hDEAD_BEEF, "sw_rf3");

    // jump with PC top nibble preserved
    load_reg(5'd5, 32'h4000_0004);
    c = '0; c.irw = 1;
    cyc(c, {6'h0, 5'd5, 21'd0}, 1'b1, "j_ir", K_NONE, 0);
    idle("j_wait", K_NONE, 0);
    c = '0; c.srca = 1; c.pcw = 1;
    cyc(c, 32'h0, 1'b1, "j_setpc", K_NONE, 0);
    c = '0; c.irw = 1;
    cyc(c, 32'h0800_0040, 1'b1, "j_fetch", K_ADDR, 32'h4000_0004);
    c = '0; c.pcw = 1; c.pcs = 2'b10;
    cyc(c, 32'h0, 1'b1, "j_exec", K_NONE, 0);
    idle("j_pc", K_ADDR, 32'h4000_0100);

    // write to r0 is discarded
    load_reg(5'd0, 32'd123);
    peek_reg(5'd0, 32'h0, "r0_read");

    // reset during a RegWrite cycle
    c = '0; c.irw = 1;
    cyc(c, {6'h23, 5'd0, 5'd7, 16'd0}, 1'b1, "rm_ir", K_NONE, 0);
    cyc('0, 32'h99, 1'b1, "rm_mdr", K_NONE, 0);
    c = '0; c.rw = 1; c.m2r = 1; c.pcw = 1;
    cyc(c, 32'h0, 1'b0, "rm_reset", K_NONE, 0);
    idle("rm_pc", K_ADDR, 32'h0);
    peek_reg(5'd7, 32'h0, "rm_rf7");
    peek_reg(5'd3, 32'h0, "rm_rf3");

    // randomized control words and memory data
    for (int i = 0; i < 3000; i++) begin
      c = ctrl_t'(16'($urandom));
      cyc(c, $urandom, ($urandom_range(0, 99) != 0), "rand", K_NONE, 0);
    end

    drained = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (q.size() == 0) begin
        drained = 1;
        break;
      end
    end
    if (!drained) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Datapath half of the multicycle MIPS core: consumes the per-cycle control word from the multicycle controller and returns the opcode field and ALU zero flag to it.
- Holds the PC, IR, MDR, A, B and ALUOut registers, a 32x32 register file, the ALU with its local ALU-control decode, and the single shared memory port.
- Memory is external, with a combinational read: mem_rdata is valid in the same cycle as mem_addr/mem_read.

Parameters:
- DATA_W, 32: datapath width (MIPS-I fixes this at 32).
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, RegDst, ALUSrcA  in  1 each  control strobes from the controller.
- PCSource  in  2  {PCSource1,PCSource0}.
- ALUOp  in  2  {ALUOp1,ALUOp0}.
- ALUSrcB  in  2  {ALUSrcB1,ALUSrcB0}.
- opcode  out  6  IR[31:26], to the controller.
- zero  out  1  combinational; ALU result == 0.
- mem_addr  out  32  IorD ? ALUOut : PC.
- mem_wdata  out  32  B register.
- mem_rdata  in  32  read data, same cycle.
- mem_read, mem_write  out  1  pass-through of MemRead/MemWrite, gated low while rst_n=0.

Behaviour:
- Reset (rst_n=0 at a rising edge): PC=RESET_PC; IR, MDR, A, B, ALUOut = 0; all 32 register-file entries = 0. Reset takes priority over every control input, including mid-instruction. Outputs then read opcode=0 and mem_addr=RESET_PC.
- ALU A operand: ALUSrcA ? A : PC.
- ALU B operand by ALUSrcB:
  - 00: B
  - 01: 32'd4
  - 10: sign-extended IR[15:0]
  - 11: sign-extended IR[15:0] << 2
- ALU control:
  - ALUOp 00: add.
  - ALUOp 01: subtract.
  - ALUOp 10: decode funct IR[5:0] as 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0). Any other funct gives add.
  - ALUOp 11: add.
- Arithmetic wraps modulo 2^32; no overflow trap.
- Every cycle, unconditionally: ALUOut <= ALU result; MDR <= mem_rdata; A <= rf[IR[25:21]]; B <= rf[IR[20:16]].
- IR <= mem_rdata only when IRWrite=1.
- PC next value by PCSource:
  - 00: ALU result
  - 01: ALUOut
  - 10: {PC[31:28], IR[25:0], 2'b00}
  - 11: PC (hold)
- PC enable = PCWrite | (PCWriteCond & zero). PCWriteCond uses the same-cycle zero.
- Register file write, on RegWrite=1:
  - address = RegDst ? IR[15:11] : IR[20:16]
  - data = MemToReg ? MDR : ALUOut
  - writes to register 0 are discarded; rf[0] always reads 0.
- Read-during-write: A/B capture the pre-write value in that cycle; the new value is visible the following cycle.
- IRWrite and PCWrite in the same cycle (fetch): IR captures mem_rdata at the old PC; PC updates at the same edge.
- MemRead and MemWrite both 1: both are passed through unmodified; arbitration is the memory's responsibility.

Decomposition:
- Shared package mips_pkg holds:
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
  - funct constants: FUNCT_ADD/SUB/AND/OR/SLT.
  - ALUSrcB encodings: SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2.
  - PCSource encodings: PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_HOLD.
  - Opcode constants shared with the controller.
- One sub-module: mips_regfile. It has 2 combinational read ports and 1 synchronous write port, synchronous active-low clear, and hardwired-zero r0.
- ALU and ALU-control stay inline.

Test Plan:
- Reset: rst_n low 2 cycles with PCWrite=1, RegWrite=1 driven -> PC=RESET_PC, IR=0, opcode=0, rf all 0, mem_read/mem_write=0.
- Fetch: mem_rdata=32'h0122_5020 (add $10,$9,$2), IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1 -> IR=32'h0122_5020, PC=4, opcode=0.
- R-type: preload $9=7, $2=5; execute ALUSrcA=1, ALUSrcB=00, ALUOp=10, then RegDst=1, MemToReg=0, RegWrite=1 -> rf[10]=12. Repeat with funct 0x2A, $9=-1, $2=1 -> rf[10]=1.
- Branch: beq with $1=$2=3, imm=16'hFFFF, PC=8 -> decode cycle ALUOut=8+(-4)=4; compare cycle ALUOp=01, PCWriteCond=1, PCSource=01 -> zero=1, PC=4. With $1≠$2 -> PC unchanged at 8.
- Load/store: lw $3,8($4), $4=0x100 -> mem_addr=0x108 with IorD=1; mem_rdata=0xDEADBEEF; then MemToReg=1, RegDst=0, RegWrite=1 -> rf[3]=0xDEADBEEF. sw -> mem_write=1, mem_wdata=B.
- Jump / r0 / reset mid-op: PCSource=10, IR=32'h0800_0040, PC=32'h4000_0004 -> PC=32'h4000_0100. A write to r0 -> reads remain 0. rst_n low during a RegWrite cycle -> no write; all registers zero.
